// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the five-stage CPU pipeline stage registers:
// occupancy state encoding, default bundle widths and the per-boundary
// control/data widths used when pipe_stage_reg is instantiated at
// IF/ID, ID/EX, EX/MEM and MEM/WB.
package cpu_pipe_pkg;

  // Occupancy of a stage register. TWO is only reachable when the skid
  // register is built in (PIPE_STAGE_SKID_EN).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  // Default widths of a generic stage register.
  localparam int DEF_CTRL_W = 4;   // MemtoReg, RegWrite, R31toReg, JaltoReg
  localparam int DEF_DATA_W = 69;  // alu 32 + rd 32 + dest reg 5
  localparam int DEF_CNT_W  = 16;  // stall counter

  // IF/ID: instruction-valid hint; pc+4 and the fetched instruction.
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;

  // ID/EX: RegDst, AluSrc, AluOp[2:0], MemRead, MemWrite, MemtoReg, RegWrite;
  // rs 32 + rt 32 + imm 32 + pc+4 32 + rd 5 + rt idx 5 + shamt 5.
  localparam int IDEX_CTRL_W  = 9;
  localparam int IDEX_DATA_W  = 143;

  // EX/MEM: MemRead, MemWrite, MemtoReg, RegWrite, R31toReg, JaltoReg;
  // alu result 32 + store data 32 + dest reg 5.
  localparam int EXMEM_CTRL_W = 6;
  localparam int EXMEM_DATA_W = 69;

  // MEM/WB: MemtoReg, RegWrite, R31toReg, JaltoReg;
  // alu result 32 + load data 32 + dest reg 5.
  localparam int MEMWB_CTRL_W = 4;
  localparam int MEMWB_DATA_W = 69;

  // True when the state has a beat sitting in the main (output) register.
  function automatic logic holds_beat(input pipe_state_e s);
    return (s != EMPTY);
  endfunction

endpackage : cpu_pipe_pkg

// File: rtl/pipe_skid_buf.sv
// Second storage slot of a pipeline stage register. Holds the one extra
// beat that arrives in the cycle after the downstream stage stops
// accepting, so the upstream ready can be a plain register. Clear wins
// over load; the data word is only meaningful while valid_o is high.
module pipe_skid_buf
  import cpu_pipe_pkg::*;
#(
  parameter int W = DEF_CTRL_W + DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Capture the overflow beat; invalidate when drained or squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : pipe_skid_buf

// File: rtl/pipe_stage_reg.sv
// Generic flow-controlled pipeline stage register for the five-stage CPU.
// Carries a control bundle (cleared on bubble/flush) and a data bundle
// (held, only reset clears it) from one stage to the next.
//
// Build option: define PIPE_STAGE_SKID_EN to add a skid register and the
// TWO state, which makes in_ready a register output with no combinational
// path from out_ready. Without it in_ready is !out_valid | out_ready.
//
// Handshake: a beat moves across a port in a cycle where valid and ready
// are both high at the rising edge (accept = in_valid & in_ready,
// pop = out_valid & out_ready). Once out_valid is raised the beat and its
// ctrl/data stay stable until popped or flushed; in_ctrl/in_data are only
// looked at while in_valid is high. flush discards everything held plus
// any beat offered in the same cycle, and the presented output beat counts
// as not consumed. rst has priority over everything.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state_o
);

  localparam int BEAT_W = CTRL_W + DATA_W;

  pipe_state_e       state_q, state_d;
  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  logic accept;
  logic pop;
  logic load_main_in;  // main register takes the incoming beat
  logic clr_ctrl;      // stage goes empty: drop control bits (bubble)

`ifdef PIPE_STAGE_SKID_EN
  logic              ready_q;
  logic              skid_load;
  logic              skid_clr;
  logic              load_main_skid;
  logic              skid_valid;
  logic [BEAT_W-1:0] skid_beat;

  // Registered ready: low exactly while both slots are occupied.
  assign in_ready = ready_q & ~rst;
`else
  // Single slot: room now if empty or if the held beat leaves this cycle.
  assign in_ready = ~rst & (~valid_q | out_ready);
`endif

  assign accept = in_valid & in_ready;
  assign pop    = valid_q & out_ready;

  // Next occupancy and which storage moves; flush overrides accept/pop.
  always_comb begin
    state_d      = state_q;
    load_main_in = 1'b0;
    clr_ctrl     = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    load_main_skid = 1'b0;
`endif
    if (flush) begin
      state_d  = EMPTY;
      clr_ctrl = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_clr = 1'b1;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            // Only the skid build can accept while the output is stalled.
`ifdef PIPE_STAGE_SKID_EN
            state_d   = TWO;
            skid_load = 1'b1;
`endif
          end else if (pop) begin
            state_d  = EMPTY;
            clr_ctrl = 1'b1;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        TWO: begin
          // in_ready is low here, so only a pop can move anything.
          if (pop && skid_valid) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
`endif
        default: begin
          state_d  = EMPTY;
          clr_ctrl = 1'b1;
        end
      endcase
    end
  end

  // Occupancy FSM and main register; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= holds_beat(state_d);
      if (clr_ctrl) begin
        ctrl_q <= '0;
      end else if (load_main_in) begin
        ctrl_q <= in_ctrl;
        data_q <= in_data;
      end
`ifdef PIPE_STAGE_SKID_EN
      else if (load_main_skid) begin
        ctrl_q <= skid_beat[BEAT_W-1:DATA_W];
        data_q <= skid_beat[DATA_W-1:0];
      end
`endif
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // Ready for the next cycle follows the occupancy being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_d != TWO);
    end
  end

  pipe_skid_buf #(
    .W (BEAT_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clr_i   (skid_clr),
    .data_i  ({in_ctrl, in_data}),
    .valid_o (skid_valid),
    .data_o  (skid_beat)
  );
`endif

  // Count stalled cycles (beat presented, not taken); saturate, rst-only clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (valid_q && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid   = valid_q;
  assign out_ctrl    = ctrl_q;
  assign out_data    = data_q;
  assign stall_cnt   = cnt_q;
  assign dbg_state_o = state_q;

endmodule : pipe_stage_reg

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register for the five-stage CPU, replacing fixed per-boundary latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Carries a control-bit bundle and a data bundle from one stage to the next under a valid/ready handshake. Supports synchronous flush for branch/jump squash, bubble insertion with cleared control bits, an optional two-entry skid buffer for full throughput with registered ready, and a saturating stall counter.

## Interface
- CTRL_W, 4: width of control bundle (e.g. MemtoReg, RegWrite, R31toReg, JaltoReg); cleared on bubble/flush.
- DATA_W, 69: width of data bundle (e.g. alu 32 + rd 32 + dest reg 5); never cleared except by reset.
- CNT_W, 16: stall counter width.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  squash all held beats this cycle.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream data.
- out_valid  out  1  beat present at output.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  registered control bits; all-zero whenever out_valid=0.
- out_data  out  DATA_W  registered data; holds last value when out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

## Operation
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main register (drives outputs) plus, with skid, one skid register.
- States: EMPTY, ONE (main valid), TWO (main + skid valid; skid build only).
- EMPTY: accept -> ONE, main <= in.
- ONE: accept & pop -> ONE, main <= in; accept & !pop -> TWO, skid <= in (skid build) / not reachable (no-skid build); pop & !accept -> EMPTY; neither -> ONE hold.
- TWO: pop -> ONE, main <= skid; no accept possible; else hold.
- Beats exit in arrival order; no beat duplicated or dropped except by flush.
- Bubble: on entering EMPTY, out_ctrl <= 0 (RegWrite etc. deasserted), out_data unchanged.
- flush: next state EMPTY, out_ctrl <= 0, skid invalidated; overrides accept and pop in same cycle (incoming beat discarded, presented output beat counts as not consumed).
- stall_cnt: +1 each cycle out_valid & !out_ready, saturates at 2^CNT_W-1; cleared only by rst (flush does not clear).
- rst: highest priority; state EMPTY, out_valid 0, out_ctrl 0, out_data 0, skid 0, stall_cnt 0; in_ready 0 during rst cycle, 1 the cycle after.

## Timing
- Latency: beat accepted in cycle N appears at out_* in cycle N+1.
- Throughput: 1 beat/cycle with out_ready held high, both builds.
- Skid build: in_ready is a register output = !(state==TWO) after update; no combinational path out_ready -> in_ready.
- No-skid build: in_ready = !out_valid | out_ready (combinational, same cycle).
- out_valid, out_ctrl, out_data always register outputs.
- in_* values must be stable only while in_valid=1; ignored otherwise.

## Configuration
- PIPE_STAGE_SKID_EN defined: skid register and TWO state present; registered in_ready; tolerates one extra beat after out_ready drops.
- Undefined: single register, states EMPTY/ONE only, combinational in_ready as above; all other behaviour identical.

## Structure
- Shared package cpu_pipe_pkg: state enum (EMPTY, ONE, TWO), default widths CTRL_W/DATA_W/CNT_W, per-boundary ctrl/data width constants for IF/ID, ID/EX, EX/MEM, MEM/WB.
- Sub-module pipe_skid_buf: skid register + valid bit, instantiated only under PIPE_STAGE_SKID_EN; top holds FSM, main register, stall counter.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1, in_ctrl=4'hF -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0; in_ready=1 first cycle after rst drops.
- Streaming: 8 beats data 1..8, ctrl 4'b0101, out_ready=1 -> data 1..8 at out in cycles N+1..N+8, no gaps.
- Backpressure (skid): stream, drop out_ready 3 cycles -> one extra beat absorbed, in_ready=0 next cycle, stall_cnt +3, order preserved on release.
- Flush: state TWO holding beats 5,6, flush with in_valid=1 data 7 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; beats 5,6,7 never appear.
- Bubble: single beat ctrl 4'b1111, then in_valid=0 -> after pop out_ctrl=0, out_data holds beat value.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt sticks at 15; flush leaves it 15, rst clears to 0.
